systolic_mac_pe: RTL

Parametrised output-stationary MAC processing element for the systolic array; successor to the basic 32-bit accumulate-and-forward PE. Operands flow through registered east/south forwarding ports with valid qualifiers. Products go through a two-stage multiply/accumulate pipeline with optional saturation. The accumulator is drained through a snapshot register with a valid/ready handshake, so accumulation of the next tile continues while the result is held for readout.

---
 rtl/systolic_mac_pe.sv | 116 +++++++++++
 1 files changed

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: output-stationary MAC PE with operand forwarding, saturating accumulate and handshaked drain
module systolic_mac_pe #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_valid_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_valid_out,
    input  logic              acc_clear,
    input  logic              drain_req,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_ovf,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              drain_err
);
    localparam int EXT_W = ACC_W + 1 - 2 * DATA_W;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    localparam logic [ACC_W-1:0] ACC_MAX = {SIGNED == 0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [DATA_W-1:0]   a_q, b_q;
    logic                av_q, bv_q;
    logic [2*DATA_W-1:0] p_q, p_d, prod;
    logic                pv_q, pv_d;
    logic [ACC_W-1:0]    acc_q, acc_d, res, out_q, out_d;
    logic [ACC_W:0]      sum;
    logic                ovf_q, ovf_d, ovf_now;
    logic                oovf_q, oovf_d;
    logic                pend_q, pend_d;
    logic                err_q, err_d;
    logic [0:0]          state_q, state_d;
    logic                sa, sb, ps, drain_ok, snap, flush;

    assign a_out       = a_q;
    assign a_valid_out = av_q;
    assign b_out       = b_q;
    assign b_valid_out = bv_q;
    assign acc_out     = out_q;
    assign acc_ovf     = oovf_q;
    assign acc_valid   = state_q == HOLD;
    assign drain_err   = err_q;

    // Multiply, extend into the one-bit-wider sum, then clamp or wrap the accumulate result
    always_comb begin
        sa       = SIGNED != 0 && a_in[DATA_W-1];
        sb       = SIGNED != 0 && b_in[DATA_W-1];
        prod     = {{DATA_W{sa}}, a_in} * {{DATA_W{sb}}, b_in};
        ps       = SIGNED != 0 && p_q[2*DATA_W-1];
        sum      = {SIGNED != 0 && acc_q[ACC_W-1], acc_q} + (pv_q ? {{EXT_W{ps}}, p_q} : '0);
        ovf_now  = SIGNED != 0 ? sum[ACC_W] ^ sum[ACC_W-1] : sum[ACC_W];
        res      = ovf_now && SATURATE != 0 ? (SIGNED != 0 && sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
        drain_ok = drain_req && !acc_clear && !pend_q && (state_q == IDLE || acc_ready);
        snap     = pend_q && !acc_clear;
        flush    = acc_clear || snap;
        p_d      = a_valid_in && b_valid_in ? prod : p_q;
        pv_d     = a_valid_in && b_valid_in;
        acc_d    = flush ? '0 : res;
        ovf_d    = !flush && (ovf_q || ovf_now);
        pend_d   = drain_ok;
        out_d    = snap ? res : out_q;
        oovf_d   = snap ? ovf_q || ovf_now : oovf_q;
        err_d    = err_q || (drain_req && !acc_clear && !drain_ok);
        state_d  = snap ? HOLD : (state_q == HOLD && acc_ready ? IDLE : state_q);
    end

    // Forwarding registers pass operands through unconditionally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            av_q <= 1'b0;
            bv_q <= 1'b0;
        end else begin
            a_q  <= a_in;
            b_q  <= b_in;
            av_q <= a_valid_in;
            bv_q <= b_valid_in;
        end
    end

    // Product stage, accumulator, drain snapshot and hold state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            pv_q    <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
            out_q   <= '0;
            oovf_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            p_q     <= p_d;
            pv_q    <= pv_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            oovf_q  <= oovf_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end
endmodule
